// File: rtl/intr_sig_gen_array_if.sv
// intr_sig_gen_array_if: status/config inputs and request outputs of intr_sig_gen_array.
// The intr_ack lines exist only when INTR_SIG_GEN_ARRAY_ACK_EN is defined.
interface intr_sig_gen_array_if #(
    parameter int NUM_CH = 4,
    parameter int PW_BW  = 5
);
    logic [NUM_CH-1:0]       intr_stat;
    logic [NUM_CH-1:0]       intr_en;
    logic [2*NUM_CH-1:0]     trig_mode;
    logic [PW_BW*NUM_CH-1:0] pulse_width;
    logic [NUM_CH-1:0]       intr_sig;
    logic                    intr_any;
`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
    logic [NUM_CH-1:0]       intr_ack;
    modport master (output intr_stat, intr_en, trig_mode, pulse_width, intr_ack, input intr_sig, intr_any);
    modport slave  (input intr_stat, intr_en, trig_mode, pulse_width, intr_ack, output intr_sig, intr_any);
`else
    modport master (output intr_stat, intr_en, trig_mode, pulse_width, input intr_sig, intr_any);
    modport slave  (input intr_stat, intr_en, trig_mode, pulse_width, output intr_sig, intr_any);
`endif
endinterface

// File: rtl/intr_sig_gen_array.sv
// intr_sig_gen_array: per-channel edge/pulse/level interrupt request generator with OR-aggregate.
// Define INTR_SIG_GEN_ARRAY_ACK_EN to enable early acknowledge of a request in HOLD.
module intr_sig_gen_array #(
    parameter int NUM_CH          = 4,
    parameter int MAX_PULSE_WIDTH = 16,
    parameter int PW_BW           = $clog2(MAX_PULSE_WIDTH + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    intr_sig_gen_array_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD, CLR} state_t;
    localparam logic [PW_BW-1:0] MAX_W = PW_BW'(MAX_PULSE_WIDTH);
    logic [NUM_CH-1:0] sig;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           state, state_nxt;
        logic [PW_BW-1:0] cnt, cnt_nxt, width, eff_w;
        logic [1:0]       mode;
        logic             stat, en, ack, clr;
        assign stat  = bus.intr_stat[c];
        assign en    = bus.intr_en[c];
        assign mode  = bus.trig_mode[2*c +: 2];
        assign width = bus.pulse_width[PW_BW*c +: PW_BW];
        assign eff_w = (width == '0) ? PW_BW'(1) : (width > MAX_W) ? MAX_W : width;
`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
        assign ack = bus.intr_ack[c];
`else
        assign ack = 1'b0;
`endif
        // >= rather than == keeps a pulse finite if the width shrinks mid-HOLD
        assign clr = ack | ((mode == 2'd2) ? !stat : (mode == 2'd1) ? (cnt >= eff_w - 1'b1) : 1'b1);
        always_comb begin
            state_nxt = state;
            if (!en)
                state_nxt = IDLE;
            else if (state == IDLE)
                state_nxt = stat ? HOLD : IDLE;
            else if (state == HOLD)
                state_nxt = !clr ? HOLD : (mode == 2'd2) ? IDLE : CLR;
            else
                state_nxt = stat ? CLR : IDLE;
            cnt_nxt = (state == IDLE || !en) ? '0 :
                      (state_nxt == HOLD && cnt < eff_w - 1'b1) ? cnt + 1'b1 : cnt;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
            end
        end
        assign sig[c] = (state == HOLD);
    end
    assign bus.intr_sig = sig;
    assign bus.intr_any = |sig;
endmodule

// File: tb/tb_intr_sig_gen_array.sv
// tb_intr_sig_gen_array: directed scenarios plus randomized run against a behavioural model.
module tb_intr_sig_gen_array;
    localparam int N = 4, MAXW = 16, PW = 5;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    intr_sig_gen_array_if #(.NUM_CH(N), .PW_BW(PW)) bus ();
    intr_sig_gen_array #(.NUM_CH(N), .MAX_PULSE_WIDTH(MAXW), .PW_BW(PW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int pass_cnt = 0, total = 0;
    bit m_out[N];
    bit m_wait[N];
    int m_hi[N];

    function automatic logic [N-1:0] m_vec();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_out[c];
        return v;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_out[c] = 0; m_wait[c] = 0; m_hi[c] = 0;
        end
    endfunction

    // request rules: a request starts on sampled status, ends per mode; edge/pulse need status low before re-arming
    function automatic void model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int c = 0; c < N; c++) begin
            int  md, w;
            bit  st, a, done;
            st = bus.intr_stat[c];
            md = int'(bus.trig_mode[2*c +: 2]);
            w  = int'(bus.pulse_width[PW*c +: PW]);
            w  = (w == 0) ? 1 : (w > MAXW) ? MAXW : w;
`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
            a = bus.intr_ack[c];
`else
            a = 0;
`endif
            if (!bus.intr_en[c]) begin
                m_out[c] = 0; m_wait[c] = 0; m_hi[c] = 0;
            end else if (m_out[c]) begin
                done = a || (md == 2 ? !st : md == 1 ? (m_hi[c] + 1 >= w) : 1'b1);
                if (done) begin
                    m_out[c] = 0; m_wait[c] = (md != 2);
                end else m_hi[c]++;
            end else if (m_wait[c]) begin
                if (!st) m_wait[c] = 0;
            end else if (st) begin
                m_out[c] = 1; m_hi[c] = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_ch(input int c, input int md, input int w);
        bus.trig_mode[2*c +: 2] = 2'(md);
        bus.pulse_width[PW*c +: PW] = PW'(w);
    endtask

    task automatic quiesce();
        bus.intr_en = '0;
        bus.intr_stat = '0;
`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
        bus.intr_ack = '0;
`endif
        tick();
        tick();
    endtask

    task automatic test_reset();
        #3;
        total++; if (bus.intr_sig !== '0) $display("FAIL reset_sig got=%b exp=0", bus.intr_sig); else pass_cnt++;
        total++; if (bus.intr_any !== 1'b0) $display("FAIL reset_any got=%b exp=0", bus.intr_any); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pulse();
        quiesce();
        set_ch(0, 1, 5);
        bus.intr_en = 4'b0001;
        bus.intr_stat = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            total++; if (bus.intr_sig[0] !== (k <= 5)) $display("FAIL pulse5 k=%0d got=%b exp=%b", k, bus.intr_sig[0], k <= 5); else pass_cnt++;
        end
        bus.intr_stat = 4'b0000;
        tick();
        tick();
        bus.intr_stat = 4'b0001;
        tick();
        total++; if (bus.intr_sig[0] !== 1'b1) $display("FAIL pulse_retrig got=%b exp=1", bus.intr_sig[0]); else pass_cnt++;
    endtask

    task automatic test_edge_level();
        logic [N-1:0] exp;
        quiesce();
        set_ch(1, 0, 0);
        set_ch(2, 2, 0);
        bus.intr_en = 4'b0110;
        bus.intr_stat = 4'b0110;
        for (int k = 1; k <= 9; k++) begin
            if (k == 7) bus.intr_stat = 4'b0000;
            tick();
            exp = {1'b0, 1'(k <= 6), 1'(k == 1), 1'b0};
            total++; if (bus.intr_sig !== exp) $display("FAIL edge_level k=%0d got=%b exp=%b", k, bus.intr_sig, exp); else pass_cnt++;
            total++; if (bus.intr_any !== |exp) $display("FAIL edge_level_any k=%0d got=%b exp=%b", k, bus.intr_any, |exp); else pass_cnt++;
        end
    endtask

    task automatic test_width_sat();
        quiesce();
        set_ch(3, 1, 0);
        bus.intr_en = 4'b1000;
        bus.intr_stat = 4'b1000;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (bus.intr_sig[3] !== (k == 1)) $display("FAIL width0 k=%0d got=%b exp=%b", k, bus.intr_sig[3], k == 1); else pass_cnt++;
        end
        quiesce();
        set_ch(3, 1, 31);
        bus.intr_en = 4'b1000;
        bus.intr_stat = 4'b1000;
        for (int k = 1; k <= 18; k++) begin
            tick();
            total++; if (bus.intr_sig[3] !== (k <= 16)) $display("FAIL width31 k=%0d got=%b exp=%b", k, bus.intr_sig[3], k <= 16); else pass_cnt++;
        end
    endtask

    task automatic test_enable();
        quiesce();
        set_ch(0, 1, 8);
        bus.intr_en = 4'b0001;
        bus.intr_stat = 4'b0001;
        tick();
        tick();
        total++; if (bus.intr_sig[0] !== 1'b1) $display("FAIL en_pre got=%b exp=1", bus.intr_sig[0]); else pass_cnt++;
        bus.intr_en = 4'b0000;
        tick();
        total++; if (bus.intr_sig[0] !== 1'b0) $display("FAIL en_drop got=%b exp=0", bus.intr_sig[0]); else pass_cnt++;
        bus.intr_en = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            tick();
            total++; if (bus.intr_sig[0] !== (k <= 8)) $display("FAIL en_again k=%0d got=%b exp=%b", k, bus.intr_sig[0], k <= 8); else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] exp;
        quiesce();
        for (int c = 0; c < N; c++) set_ch(c, 1, 8);
        bus.intr_en = 4'b1111;
        bus.intr_stat = 4'b1111;
        tick(); tick(); tick();
        total++; if (bus.intr_sig !== 4'b1111) $display("FAIL rst_pre got=%b exp=1111", bus.intr_sig); else pass_cnt++;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (bus.intr_sig !== '0 || bus.intr_any !== 1'b0) $display("FAIL rst_mid got=%b/%b exp=0000/0", bus.intr_sig, bus.intr_any); else pass_cnt++;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp = (k <= 8) ? 4'b1111 : 4'b0000;
            total++; if (bus.intr_sig !== exp) $display("FAIL rst_after k=%0d got=%b exp=%b", k, bus.intr_sig, exp); else pass_cnt++;
        end
    endtask

`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
    task automatic test_ack();
        quiesce();
        set_ch(0, 1, 10);
        set_ch(2, 2, 0);
        bus.intr_en = 4'b0001;
        bus.intr_stat = 4'b0001;
        tick(); tick(); tick();
        bus.intr_ack = 4'b0001;
        tick();
        total++; if (bus.intr_sig[0] !== 1'b0) $display("FAIL ack_pulse got=%b exp=0", bus.intr_sig[0]); else pass_cnt++;
        bus.intr_ack = 4'b0000;
        tick(); tick();
        total++; if (bus.intr_sig[0] !== 1'b0) $display("FAIL ack_clr got=%b exp=0", bus.intr_sig[0]); else pass_cnt++;
        quiesce();
        bus.intr_en = 4'b0100;
        bus.intr_stat = 4'b0100;
        tick();
        bus.intr_ack = 4'b0100;
        tick();
        total++; if (bus.intr_sig[2] !== 1'b0) $display("FAIL ack_level_low got=%b exp=0", bus.intr_sig[2]); else pass_cnt++;
        bus.intr_ack = 4'b0000;
        tick();
        total++; if (bus.intr_sig[2] !== 1'b1) $display("FAIL ack_level_re got=%b exp=1", bus.intr_sig[2]); else pass_cnt++;
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] exp;
        quiesce();
        for (int r = 0; r < 8; r++) begin
            bus.intr_en = '0;
            tick();
            for (int c = 0; c < N; c++) set_ch(c, $urandom_range(0, 3), $urandom_range(0, 31));
            bus.intr_en = N'($urandom);
            for (int k = 0; k < 50; k++) begin
                bus.intr_stat = bus.intr_stat ^ N'($urandom & $urandom);
`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
                bus.intr_ack = N'($urandom & $urandom & $urandom);
`endif
                tick();
                exp = m_vec();
                total++; if (bus.intr_sig !== exp) $display("FAIL rand r=%0d k=%0d got=%b exp=%b", r, k, bus.intr_sig, exp); else pass_cnt++;
                total++; if (bus.intr_any !== |exp) $display("FAIL rand_any r=%0d k=%0d got=%b exp=%b", r, k, bus.intr_any, |exp); else pass_cnt++;
            end
        end
    endtask

    initial begin
        bus.intr_stat = '0;
        bus.intr_en = '0;
        bus.trig_mode = '0;
        bus.pulse_width = '0;
`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
        bus.intr_ack = '0;
`endif
        model_reset();
        test_reset();
        test_pulse();
        test_edge_level();
        test_width_sat();
        test_enable();
        test_async_reset();
`ifdef INTR_SIG_GEN_ARRAY_ACK_EN
        test_ack();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/intr_sig_gen_array.md
# intr_sig_gen_array

Multi-channel interrupt signal generator: converts NUM_CH registered interrupt status bits into interrupt request lines, each channel with its own run-time trigger mode (edge, pulse, level), pulse width and enable. It sits between peripheral status registers and the interrupt controller. It also drives one aggregated request line, so a block with many interrupt sources needs only one instance.

## Interface
- NUM_CH, 4, number of independent channels (1..32)
- MAX_PULSE_WIDTH, 16, largest programmable pulse width in cycles (>=1)
- PW_BW, $clog2(MAX_PULSE_WIDTH+1), derived width of the pulse-width field and counters
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_intr_stat  input  NUM_CH  registered interrupt status, one bit per channel
- i_intr_en  input  NUM_CH  channel enable
- i_trig_mode  input  2*NUM_CH  per-channel trigger mode: 0 edge, 1 pulse, 2 level, 3 reserved (treated as edge)
- i_pulse_width  input  PW_BW*NUM_CH  per-channel pulse width in cycles; 0 is treated as 1; values >MAX_PULSE_WIDTH saturate to MAX_PULSE_WIDTH
- i_intr_ack  input  NUM_CH  early acknowledge (present only with INTR_SIG_GEN_ARRAY_ACK_EN)
- o_intr_sig  output  NUM_CH  per-channel interrupt request
- o_intr_any  output  1  OR of o_intr_sig

## Operation
- Each channel has its own FSM: IDLE, HOLD, CLR; state register and PW_BW-bit counter per channel.
- IDLE -> HOLD when i_intr_stat[c] && i_intr_en[c].
- HOLD -> exit when clr[c]:
  - Edge mode: clr is always true, so HOLD lasts 1 cycle.
  - Pulse mode: clr = (cnt == eff_width-1).
  - Level mode: clr = !i_intr_stat[c].
- On exit from HOLD: level mode goes to IDLE; edge and pulse modes go to CLR.
- CLR -> IDLE when !i_intr_stat[c]. This re-arms the channel, so one status assertion produces exactly one request in edge and pulse modes.
- Counter: cleared while in IDLE; +1 when the next state is HOLD; otherwise held. It never exceeds eff_width-1, so it never wraps.
- o_intr_sig[c] = (state[c] == HOLD). It is decoded only from the state register and is glitch-free.
- o_intr_any = |o_intr_sig.
- Enable low: the channel goes to IDLE on the next edge from any state, and the counter clears.
- i_trig_mode and i_pulse_width are sampled every cycle.
  - Changing them while a channel is in HOLD takes effect immediately.
  - Software must change them only when the channel is disabled; behaviour in that case is defined but not guaranteed to be meaningful.
- Channels are fully independent; simultaneous events on different channels never interact.

## Timing
- Reset (async, i_rst_n low): all states IDLE, counters 0, o_intr_sig = 0, o_intr_any = 0, applied immediately. Reset asserted mid-pulse drops the output at once.
- Latency: status sampled high at edge t gives o_intr_sig high from t+1 (one cycle).
- Pulse mode, width W: output high for exactly W cycles, then low for at least 1 cycle (CLR or IDLE) before any re-trigger.
- Edge mode: output high for exactly 1 cycle.
- Level mode: output falls one cycle after status is sampled low.
- Status dropping in pulse mode mid-HOLD does not shorten the pulse; the FSM then passes CLR -> IDLE on the next cycle.
- Status still high when CLR is entered: the FSM stays in CLR until status goes low; no new request.

## Configuration
- INTR_SIG_GEN_ARRAY_ACK_EN defined:
  - The i_intr_ack port exists.
  - i_intr_ack[c] high while in HOLD forces clr true for that cycle. Level mode exits to IDLE (a re-trigger occurs next cycle if status is still high); edge and pulse modes exit to CLR.
  - Ack outside HOLD is ignored.
- Macro undefined: the port is absent and behaviour is exactly as in Operation.

## Test plan
- Pulse mode, width 5, ch0 status high for 20 cycles -> o_intr_sig[0] high for exactly 5 cycles starting 1 cycle after status; no second pulse until status drops and rises again.
- Edge mode on ch1 and level mode on ch2, same status waveform (high 6 cycles) -> ch1 high 1 cycle; ch2 high 6 cycles, falling 1 cycle after status falls; o_intr_any = OR of both on every cycle.
- Pulse width 0 and width 31 with MAX_PULSE_WIDTH 16 -> 1-cycle pulse and 16-cycle pulse respectively.
- i_intr_en dropped on cycle 2 of a width-8 pulse -> output low on the next edge; re-enabling with status still high -> new pulse after 1 cycle.
- i_rst_n asserted mid-pulse on all channels -> all outputs 0 immediately; after release, status held high -> fresh full-width pulses.
- ACK_EN build: ack on cycle 3 of a width-10 pulse -> pulse ends after 3 cycles and the channel enters CLR; level-mode ack with status high -> 1 low cycle, then re-assert.
